// File: rtl/dwt_pkg.sv
// Shared DWT definitions: width constants, synthesis FSM state encoding and
// the tap-array type common to the analysis and synthesis filter blocks.
package dwt_pkg;

  localparam int W_IN  = 12;
  localparam int C_IN  = 3;
  localparam int W_ACC = W_IN + C_IN + 2;
  localparam int Y_OUT = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    EVEN = 2'd2,
    ODD  = 2'd3
  } state_t;

  typedef logic signed [C_IN-1:0] tap_t;
  typedef tap_t [3:0]             tap_arr_t;

endpackage

// File: rtl/idwt_mac4.sv
// Combinational four-product signed sum; every operand is sign-extended to
// the accumulator width before multiplying.
module idwt_mac4 import dwt_pkg::*; #(
  parameter int w_in  = W_IN,
  parameter int c_in  = C_IN,
  parameter int w_acc = W_ACC
) (
  input  logic signed [c_in-1:0]  c0,
  input  logic signed [c_in-1:0]  c1,
  input  logic signed [c_in-1:0]  c2,
  input  logic signed [c_in-1:0]  c3,
  input  logic signed [w_in-1:0]  x0,
  input  logic signed [w_in-1:0]  x1,
  input  logic signed [w_in-1:0]  x2,
  input  logic signed [w_in-1:0]  x3,
  output logic signed [w_acc-1:0] sum
);

  // NOTE: sum gets a value on every path through the block, so no latch is inferred.
  always_comb begin
    sum = w_acc'(c0) * w_acc'(x0)
        + w_acc'(c1) * w_acc'(x1)
        + w_acc'(c2) * w_acc'(x2)
        + w_acc'(c3) * w_acc'(x3);
  end

endmodule

// File: rtl/idwt_synth_2ch.sv
// Two-channel DWT synthesis bank: one (low, high) pair in, even then odd sample out.
// Define IDWT_SAT_EN to saturate the output sample instead of wrapping it.
module idwt_synth_2ch import dwt_pkg::*; #(
  parameter int w_in  = W_IN,
  parameter int c_in  = C_IN,
  parameter int w_acc = W_ACC,
  parameter int y_out = Y_OUT
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [w_in-1:0]  x_lo,
  input  logic signed [w_in-1:0]  x_hi,
  input  logic signed [c_in-1:0]  g0_0,
  input  logic signed [c_in-1:0]  g0_1,
  input  logic signed [c_in-1:0]  g0_2,
  input  logic signed [c_in-1:0]  g0_3,
  input  logic signed [c_in-1:0]  g1_0,
  input  logic signed [c_in-1:0]  g1_1,
  input  logic signed [c_in-1:0]  g1_2,
  input  logic signed [c_in-1:0]  g1_3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [y_out-1:0] y,
  output logic                    y_phase
);

  state_t                  state;
  logic signed [w_in-1:0]  l0, l1, h0, h1;
  logic signed [w_acc-1:0] even_sum, odd_sum, even_acc, odd_acc;
  logic                    accept;

  function automatic logic signed [y_out-1:0] to_out(input logic signed [w_acc-1:0] a);
`ifdef IDWT_SAT_EN
    if (&a[w_acc-1:y_out-1] || ~|a[w_acc-1:y_out-1])
      to_out = a[y_out-1:0];
    else if (a[w_acc-1])
      to_out = {1'b1, {(y_out-1){1'b0}}};
    else
      to_out = {1'b0, {(y_out-1){1'b1}}};
`else
    to_out = y_out'(a);
`endif
  endfunction

  assign in_ready = (state == IDLE) || (state == ODD && out_ready);
  assign accept   = in_valid && in_ready;

  idwt_mac4 #(.w_in(w_in), .c_in(c_in), .w_acc(w_acc)) u_mac_even (
    .c0(g0_0), .c1(g0_2), .c2(g1_0), .c3(g1_2),
    .x0(l0),   .x1(l1),   .x2(h0),   .x3(h1),
    .sum(even_sum)
  );

  idwt_mac4 #(.w_in(w_in), .c_in(c_in), .w_acc(w_acc)) u_mac_odd (
    .c0(g0_1), .c1(g0_3), .c2(g1_1), .c3(g1_3),
    .x0(l0),   .x1(l1),   .x2(h0),   .x3(h1),
    .sum(odd_sum)
  );

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      l0        <= '0;
      l1        <= '0;
      h0        <= '0;
      h1        <= '0;
      even_acc  <= '0;
      odd_acc   <= '0;
      out_valid <= 1'b0;
      y         <= '0;
      y_phase   <= 1'b0;
    end else begin
      if (accept) begin
        l1 <= l0;
        h1 <= h0;
        l0 <= x_lo;
        h0 <= x_hi;
      end
      case (state)
        IDLE: if (accept) state <= CALC;
        CALC: begin
          // Taps are sampled here; the even sample goes straight to the output.
          even_acc  <= even_sum;
          odd_acc   <= odd_sum;
          y         <= to_out(even_sum);
          y_phase   <= 1'b0;
          out_valid <= 1'b1;
          state     <= EVEN;
        end
        EVEN: if (out_ready) begin
          y       <= to_out(odd_acc);
          y_phase <= 1'b1;
          state   <= ODD;
        end
        ODD: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= accept ? CALC : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idwt_synth_2ch.sv
// Directed and random-stream bench for the two-channel DWT synthesis bank.
module tb_idwt_synth_2ch;

  logic              clk = 1'b0;
  logic              rstn;
  logic              in_valid;
  logic              in_ready;
  logic signed [11:0] x_lo, x_hi;
  logic signed [2:0]  g0_0, g0_1, g0_2, g0_3;
  logic signed [2:0]  g1_0, g1_1, g1_2, g1_3;
  logic              out_valid;
  logic              out_ready;
  logic signed [11:0] y;
  logic              y_phase;

  int checks = 0;
  int errors = 0;

  idwt_synth_2ch dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_lo(x_lo), .x_hi(x_hi),
    .g0_0(g0_0), .g0_1(g0_1), .g0_2(g0_2), .g0_3(g0_3),
    .g1_0(g1_0), .g1_1(g1_1), .g1_2(g1_2), .g1_3(g1_3),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_phase(y_phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_taps(input int a0, input int a1, input int a2, input int a3,
                          input int b0, input int b1, input int b2, input int b3);
    g0_0 = 3'(a0); g0_1 = 3'(a1); g0_2 = 3'(a2); g0_3 = 3'(a3);
    g1_0 = 3'(b0); g1_1 = 3'(b1); g1_2 = 3'(b2); g1_3 = 3'(b3);
  endtask

  function automatic logic signed [11:0] model_out(input int s);
`ifdef IDWT_SAT_EN
    if (s > 2047)       model_out = 12'sd2047;
    else if (s < -2048) model_out = -12'sd2048;
    else                model_out = s[11:0];
`else
    model_out = s[11:0];
`endif
  endfunction

  // Sends pairs one at a time from IDLE with the sink always ready.
  task automatic run_pairs(input string name,
                           input logic signed [11:0] lo [2], input logic signed [11:0] hi [2],
                           input logic signed [11:0] ev [2], input logic signed [11:0] od [2]);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; x_lo = lo[i]; x_hi = hi[i];
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready pair %0d: got %b want 1", name, i, in_ready); end
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL %s latency pair %0d: out_valid %b want 0", name, i, out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || y !== ev[i] || y_phase !== 1'b0) begin
        errors++; $display("FAIL %s even pair %0d: valid %b y %0d ph %b want 1 %0d 0", name, i, out_valid, y, y_phase, ev[i]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || y !== od[i] || y_phase !== 1'b1) begin
        errors++; $display("FAIL %s odd pair %0d: valid %b y %0d ph %b want 1 %0d 1", name, i, out_valid, y, y_phase, od[i]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL %s idle pair %0d: out_valid %b want 0", name, i, out_valid); end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x_lo = '0; x_hi = '0;
    set_taps(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    checks++;
    if (out_valid !== 1'b0 || y !== 12'sd0 || y_phase !== 1'b0) begin
      errors++; $display("FAIL reset outputs: valid %b y %0d ph %b want 0 0 0", out_valid, y, y_phase);
    end
    rstn = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_lowband();
    set_taps(0, 1, 2, 3, 0, 0, 0, 0);
    out_ready = 1'b1;
    run_pairs("lowband", '{12'sd1, 12'sd2}, '{12'sd0, 12'sd0}, '{12'sd0, 12'sd2}, '{12'sd1, 12'sd5});
  endtask

  task automatic test_highband();
    set_taps(0, 0, 0, 0, 1, 1, 1, 1);
    out_ready = 1'b1;
    run_pairs("highband", '{12'sd0, 12'sd0}, '{12'sd3, -12'sd2}, '{12'sd3, 12'sd1}, '{12'sd3, 12'sd1});
  endtask

  // History here is L1 = 0, H1 = -2 from the previous test.
  task automatic test_stall();
    set_taps(1, 2, 3, -1, -1, 1, 2, -2);
    out_ready = 1'b1;
    in_valid = 1'b1; x_lo = 12'sd10; x_hi = -12'sd3;
    tick();
    x_lo = 12'sd11; x_hi = 12'sd0;
    out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || y !== 12'sd9 || y_phase !== 1'b0) begin
      errors++; $display("FAIL stall even: valid %b y %0d ph %b want 1 9 0", out_valid, y, y_phase);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || y !== 12'sd9 || y_phase !== 1'b0 || in_ready !== 1'b0) begin
        errors++; $display("FAIL stall hold %0d: valid %b y %0d ph %b rdy %b want 1 9 0 0", i, out_valid, y, y_phase, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || y !== 12'sd21 || y_phase !== 1'b1) begin
      errors++; $display("FAIL stall odd: valid %b y %0d ph %b want 1 21 1", out_valid, y, y_phase);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stall idle: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    set_taps(1, 1, 1, 1, 1, 1, 1, 1);
    out_ready = 1'b1;
    in_valid = 1'b1; x_lo = 12'sd100; x_hi = 12'sd100;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL midreset pre: out_valid %b want 1", out_valid); end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || y !== 12'sd0 || y_phase !== 1'b0) begin
      errors++; $display("FAIL midreset outputs: valid %b y %0d ph %b want 0 0 0", out_valid, y, y_phase);
    end
    in_valid = 1'b1; x_lo = 12'sd5; x_hi = 12'sd7;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || y !== 12'sd12 || y_phase !== 1'b0) begin
      errors++; $display("FAIL midreset even: valid %b y %0d ph %b want 1 12 0", out_valid, y, y_phase);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || y !== 12'sd12 || y_phase !== 1'b1) begin
      errors++; $display("FAIL midreset odd: valid %b y %0d ph %b want 1 12 1", out_valid, y, y_phase);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int g0 [4];
    int g1 [4];
    int ml1 = 0, mh1 = 0, sent = 0, got = 0, cyc = 0, last_acc = -1;
    logic signed [11:0] cur_lo, cur_hi, exp_y;
    logic signed [11:0] exp_q [$];
    logic               ph_q [$];
    logic               acc, exp_ph;
    rstn = 1'b0; in_valid = 1'b0;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g0[i] = int'($urandom_range(0, 7)) - 4;
      g1[i] = int'($urandom_range(0, 7)) - 4;
    end
    set_taps(g0[0], g0[1], g0[2], g0[3], g1[0], g1[1], g1[2], g1[3]);
    cur_lo = 12'($urandom); cur_hi = 12'($urandom);
    out_ready = 1'b1;
    while ((sent < 100 || got < 200) && cyc < 2000) begin
      in_valid = (sent < 100);
      x_lo = cur_lo; x_hi = cur_hi;
      #1;
      acc = in_valid && in_ready;
      tick();
      cyc++;
      if (acc) begin
        exp_q.push_back(model_out(g0[0]*int'(cur_lo) + g0[2]*ml1 + g1[0]*int'(cur_hi) + g1[2]*mh1));
        ph_q.push_back(1'b0);
        exp_q.push_back(model_out(g0[1]*int'(cur_lo) + g0[3]*ml1 + g1[1]*int'(cur_hi) + g1[3]*mh1));
        ph_q.push_back(1'b1);
        ml1 = int'(cur_lo); mh1 = int'(cur_hi);
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 3) begin errors++; $display("FAIL b2b spacing pair %0d: got %0d want 3", sent, cyc - last_acc); end
        end
        last_acc = cyc;
        sent++;
        cur_lo = 12'($urandom); cur_hi = 12'($urandom);
      end
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b extra sample: y %0d ph %b with none expected", y, y_phase);
        end else begin
          exp_y = exp_q.pop_front();
          exp_ph = ph_q.pop_front();
          if (y !== exp_y || y_phase !== exp_ph) begin
            errors++; $display("FAIL b2b sample %0d: y %0d ph %b want %0d %b", got, y, y_phase, exp_y, exp_ph);
          end
        end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (cyc >= 2000 || exp_q.size() != 0) begin
      errors++; $display("FAIL b2b completion: sent %0d got %0d left %0d want 100 200 0", sent, got, exp_q.size());
    end
    tick();
  endtask

  task automatic test_saturation();
    logic signed [11:0] exp_sat;
`ifdef IDWT_SAT_EN
    exp_sat = 12'sd2047;
`else
    exp_sat = 12'sd0;
`endif
    set_taps(-4, -4, -4, -4, -4, -4, -4, -4);
    out_ready = 1'b1;
    in_valid = 1'b1; x_lo = -12'sd2048; x_hi = -12'sd2048;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL sat in_ready: got %b want 1", in_ready); end
    repeat (4) tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || y !== exp_sat || y_phase !== 1'b0) begin
      errors++; $display("FAIL sat even: valid %b y %0d ph %b want 1 %0d 0", out_valid, y, y_phase, exp_sat);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || y !== exp_sat || y_phase !== 1'b1) begin
      errors++; $display("FAIL sat odd: valid %b y %0d ph %b want 1 %0d 1", out_valid, y, y_phase, exp_sat);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_lowband();
    test_highband();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
